result_bcd_converter: RTL and testbench



---
 rtl/result_bcd_converter_if.sv | 24 ++
 rtl/result_bcd_converter.sv | 108 ++++++++++
 tb/tb_result_bcd_converter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/result_bcd_converter_if.sv
// result_bcd_converter_if: result bus from the ALU/power unit into the BCD converter and its display-side outputs
interface result_bcd_converter_if #(
    parameter int M = 24,
    parameter int D = 8
);
    logic signed [M-1:0] i_result;
    logic                i_error;
    logic                i_valid;
    logic [4*D-1:0]      o_bcd;
    logic                o_neg;
    logic                o_err;
    logic                o_busy;
    logic                o_done;

    modport master (
        output i_result, i_error, i_valid,
        input  o_bcd, o_neg, o_err, o_busy, o_done
    );

    modport slave (
        input  i_result, i_error, i_valid,
        output o_bcd, o_neg, o_err, o_busy, o_done
    );
endinterface

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: signed result to sign + packed BCD via iterative double-dabble; BCD_LZ_BLANK_EN blanks leading zeros
module result_bcd_converter #(
    parameter int M = 24,
    parameter int D = 8
) (
    input logic                    CLK,
    input logic                    RST,
    result_bcd_converter_if.slave  bus
);
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    res;
    logic [M-1:0]    mag;
    logic [4*D-1:0]  scratch;
    logic [4*D-1:0]  adj;
    logic [4*D-1:0]  digits;
    logic            neg;
    logic            err;

    assign bus.o_busy = (state != IDLE);

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // next state: errors skip the conversion and go straight to DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.i_valid) next_state = bus.i_error ? DONE : ABS;
            ABS:     next_state = SHIFT;
            SHIFT:   if (cnt == CW'(M - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // add-3 correction for every scratch digit >= 5 before the next shift
    always_comb begin
        adj = scratch;
        for (int k = 0; k < D; k++)
            adj[4*k+:4] = (scratch[4*k+:4] >= 4'd5) ? scratch[4*k+:4] + 4'd3 : scratch[4*k+:4];
    end

`ifdef BCD_LZ_BLANK_EN
    logic lead;

    // replace zeros above the most significant nonzero digit with the blank code; digit 0 always shown
    always_comb begin
        digits = scratch;
        lead   = 1'b1;
        for (int k = D - 1; k > 0; k--) begin
            if (lead && scratch[4*k+:4] == 4'd0) digits[4*k+:4] = 4'hF;
            else                                 lead = 1'b0;
        end
    end
`else
    assign digits = scratch;
`endif

    // datapath: latch, take magnitude, shift M times, publish results in DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            res        <= '0;
            mag        <= '0;
            scratch    <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
            bus.o_bcd  <= '0;
            bus.o_neg  <= 1'b0;
            bus.o_err  <= 1'b0;
            bus.o_done <= 1'b0;
        end else begin
            bus.o_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        err <= bus.i_error;
                        res <= bus.i_result;
                    end
                end
                ABS: begin
                    mag     <= res[M-1] ? -res : res;
                    neg     <= res[M-1];
                    scratch <= '0;
                    cnt     <= '0;
                end
                SHIFT: begin
                    {scratch, mag} <= {adj[4*D-2:0], mag, 1'b0};
                    cnt            <= cnt + CW'(1);
                end
                DONE: begin
                    bus.o_bcd <= err ? {D{4'hE}} : digits;
                    bus.o_neg <= err ? 1'b0 : neg;
                    bus.o_err <= err;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: scoreboard bench for result_bcd_converter (define BCD_LZ_BLANK_EN for the blanking build)
module tb_result_bcd_converter;
    localparam int M = 24;
    localparam int D = 8;

    typedef struct {
        logic [4*D-1:0] bcd;
        logic           neg;
        logic           err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_done = 0;
    exp_t sb[$];

    result_bcd_converter_if #(.M(M), .D(D)) bus ();

    result_bcd_converter #(.M(M), .D(D)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [M-1:0] v, input logic e);
        exp_t   r;
        longint m;
        logic   lead;
        m = longint'(v);
        if (m < 0) m = -m;
        for (int k = 0; k < D; k++) begin
            r.bcd[4*k+:4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BCD_LZ_BLANK_EN
        lead = 1'b1;
        for (int k = D - 1; k > 0; k--) begin
            if (lead && r.bcd[4*k+:4] == 4'd0) r.bcd[4*k+:4] = 4'hF;
            else                               lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        r.neg = (v < 0);
        r.err = 1'b0;
        if (e) begin
            r.bcd = {D{4'hE}};
            r.neg = 1'b0;
            r.err = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.o_done) begin
            n_done++;
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 64'(bus.o_bcd), 64'(e.bcd));
                check("neg", 64'(bus.o_neg), 64'(e.neg));
                check("err", 64'(bus.o_err), 64'(e.err));
            end
        end
    end

    // one conversion; p1/p2 are cycles after acceptance at which a 999 strobe is poked (-1 = none)
    task automatic convert(input logic signed [M-1:0] v, input logic e, input int exp_lat,
                           input int p1 = -1, input int p2 = -1);
        int lat;
        @(negedge clk);
        bus.i_result = v;
        bus.i_error  = e;
        bus.i_valid  = 1'b1;
        sb.push_back(model(v, e));
        @(negedge clk);
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_done && lat < 100) begin
            bus.i_valid  = (lat == p1 || lat == p2);
            bus.i_result = 24'sd999;
            bus.i_error  = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.i_valid = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check("busy_after", 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        bus.i_result = '0;
        bus.i_error  = 1'b0;
        bus.i_valid  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bcd",  64'(bus.o_bcd),  64'd0);
        check("rst_neg",  64'(bus.o_neg),  64'd0);
        check("rst_err",  64'(bus.o_err),  64'd0);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        rst = 1'b0;

        convert(24'sd8, 1'b0, 26);
        convert(-24'sd27, 1'b0, 26);
        convert(-24'sd8388608, 1'b0, 26);
        convert(24'sd8388607, 1'b0, 26);
        convert(24'($urandom), 1'b1, 1);
        convert(24'sd1, 1'b0, 26);
        convert(24'sd0, 1'b0, 26);
        convert(24'sd123, 1'b0, 26, 5, 25);
        for (int i = 0; i < 4; i++) convert(24'($urandom), 1'b0, 26);

        begin
            int d0;
            @(negedge clk);
            bus.i_result = 24'sd456;
            bus.i_error  = 1'b0;
            bus.i_valid  = 1'b1;
            @(negedge clk);
            bus.i_valid = 1'b0;
            repeat (10) @(negedge clk);
            d0  = n_done;
            rst = 1'b1;
            #1;
            check("midrst_bcd",  64'(bus.o_bcd),  64'd0);
            check("midrst_busy", 64'(bus.o_busy), 64'd0);
            check("midrst_err",  64'(bus.o_err),  64'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (30) @(negedge clk);
            check("midrst_no_done", 64'(n_done - d0), 64'd0);
        end

        convert(24'sd789, 1'b0, 26);
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
